// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter sharing a single 8-bit adder.
// One operation per two cycles: grant/latch in IDLE, add/complete in ADD.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum
);
  assign sum = a + b + {7'd0, cin};
endmodule

module adder_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] result,
  output logic       busy
);

  typedef enum logic {IDLE, ADD} state_t;

  state_t     state_q, state_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic [7:0] result_q, result_d;
  logic [7:0] sum;
  logic       win;

  adder_8bit u_adder (
    .a   (op_a_q),
    .b   (op_b_q),
    .cin (1'b0),
    .sum (sum)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = 1'b0;
    win      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // On contention the requester that did not go last wins.
          win     = (req == 2'b11) ? ~last_q : req[1];
          op_a_d  = win ? a1 : a0;
          op_b_d  = win ? b1 : b0;
          gnt_d   = win ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          owner_d = win;
          state_d = ADD;
        end
      end
      ADD: begin
        result_d = sum;
        done_d   = owner_q ? 2'b10 : 2'b01;
        last_d   = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.

module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] gnt, done;
  logic [7:0] result;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  adder_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: an operation is either pending or not;
  // its sum is computed with plain integer arithmetic.
  logic       m_valid = 1'b0;
  logic       m_pending;
  int         m_who;
  int         m_last;
  int         m_a, m_b;
  logic [1:0] e_gnt, e_done;
  logic       e_busy;
  logic [7:0] e_result;

  always @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b1;
      m_pending <= 1'b0;
      m_last    <= 1;
      m_who     <= 0;
      e_gnt     <= 2'b00;
      e_done    <= 2'b00;
      e_busy    <= 1'b0;
      e_result  <= 8'h00;
    end else if (m_pending) begin
      e_result  <= 8'((m_a + m_b) % 256);
      e_done    <= 2'(1 << m_who);
      m_last    <= m_who;
      m_pending <= 1'b0;
      e_gnt     <= 2'b00;
      e_busy    <= 1'b0;
    end else if (req != 2'b00) begin
      int w;
      if (req == 2'b11) w = 1 - m_last;
      else              w = (req == 2'b10) ? 1 : 0;
      m_who     <= w;
      m_a       <= (w == 1) ? int'(a1) : int'(a0);
      m_b       <= (w == 1) ? int'(b1) : int'(b0);
      m_pending <= 1'b1;
      e_gnt     <= 2'(1 << w);
      e_done    <= 2'b00;
      e_busy    <= 1'b1;
    end else begin
      e_gnt  <= 2'b00;
      e_done <= 2'b00;
      e_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gnt",    {6'd0, gnt},  {6'd0, e_gnt});
      chk("model_done",   {6'd0, done}, {6'd0, e_done});
      chk("model_busy",   {7'd0, busy}, {7'd0, e_busy});
      chk("model_result", result, e_result);
      chk("gnt_done_excl", {6'd0, gnt & done}, 8'h00);
      chk("gnt_onehot0",  {7'd0, $onehot0(gnt)},  8'h01);
      chk("done_onehot0", {7'd0, $onehot0(done)}, 8'h01);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    #1;
    do_reset();
    sample();
    chk("reset_gnt",    {6'd0, gnt},  8'h00);
    chk("reset_done",   {6'd0, done}, 8'h00);
    chk("reset_busy",   {7'd0, busy}, 8'h00);
    chk("reset_result", result, 8'h00);

    // Single request from requester 0
    req = 2'b01; a0 = 8'h12; b0 = 8'h34;
    tick(); req = 2'b00;
    sample();
    chk("single_gnt",  {6'd0, gnt},  8'h01);
    chk("single_busy", {7'd0, busy}, 8'h01);
    tick(); sample();
    chk("single_done",   {6'd0, done}, 8'h01);
    chk("single_result", result, 8'h46);
    chk("single_busy2",  {7'd0, busy}, 8'h00);

    // Both requesters held: strict alternation starting with 0
    do_reset();
    req = 2'b11; a0 = 8'd1; b0 = 8'd1; a1 = 8'd2; b1 = 8'd2;
    for (int k = 0; k < 4; k++) begin
      tick(); sample();
      chk("rr_gnt", {6'd0, gnt}, (k % 2 == 0) ? 8'h01 : 8'h02);
      tick(); sample();
      chk("rr_done",   {6'd0, done}, (k % 2 == 0) ? 8'h01 : 8'h02);
      chk("rr_result", result, (k % 2 == 0) ? 8'h02 : 8'h04);
    end
    req = 2'b00;
    tick();

    // Overflow wraps, carry discarded
    req = 2'b10; a1 = 8'hFF; b1 = 8'h01;
    tick(); req = 2'b00;
    tick(); sample();
    chk("ovf_ff_01", result, 8'h00);
    req = 2'b10; a1 = 8'hC8; b1 = 8'h64;
    tick(); req = 2'b00;
    tick(); sample();
    chk("ovf_c8_64", result, 8'h2C);

    // Operands latched at grant; later changes ignored
    req = 2'b01; a0 = 8'h05; b0 = 8'h03;
    tick(); req = 2'b00; a0 = 8'hAA;
    sample();
    chk("latch_gnt", {6'd0, gnt}, 8'h01);
    tick(); sample();
    chk("latch_result", result, 8'h08);

    // Reset asserted in the grant cycle kills the operation
    req = 2'b10; a1 = 8'h03; b1 = 8'h04;
    tick(); req = 2'b00; rst = 1'b1;
    tick(); rst = 1'b0;
    sample();
    chk("rstadd_done",   {6'd0, done}, 8'h00);
    chk("rstadd_result", result, 8'h00);
    chk("rstadd_busy",   {7'd0, busy}, 8'h00);
    req = 2'b11;
    tick(); req = 2'b00;
    sample();
    chk("rstadd_first_gnt", {6'd0, gnt}, 8'h01);
    tick(); tick();

    // Result holds while idle
    req = 2'b01; a0 = 8'h12; b0 = 8'h34;
    tick(); req = 2'b00;
    tick(); sample();
    chk("hold_first", result, 8'h46);
    for (int k = 0; k < 10; k++) begin
      tick(); sample();
      chk("hold_result", result, 8'h46);
      chk("hold_quiet", {5'd0, gnt, done, busy}, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at %0t: got running, want finished", $time);
    $fatal(1);
  end

endmodule
